// File: rtl/button_onepulse_pkg.sv
// ============================================================================
// Module   : button_onepulse_pkg
// Brief    : State encoding and default timing constants shared by the
//            front-panel button blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package button_onepulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRS_CHK = 2'd1,
        ST_HELD    = 2'd2,
        ST_REL_CHK = 2'd3
    } btn_state_e;

    localparam int DEF_DEB_W    = 16;
    localparam int DEF_DEB_MAX  = 50000;
    localparam int DEF_LONG_W   = 24;
    localparam int DEF_LONG_MAX = 10000000;

endpackage

`default_nettype wire

// File: rtl/button_onepulse_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for a single asynchronous level input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic stage1_q;
    logic stage2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

`default_nettype wire

// File: rtl/button_onepulse.sv
// ============================================================================
// Module   : button_onepulse
// Brief    : Synchronises and debounces a push-button; emits press, release
//            and long-press one-cycle pulses plus a debounced level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_onepulse
    import button_onepulse_pkg::*;
#(
    parameter int DEB_W    = DEF_DEB_W,
    parameter int DEB_MAX  = DEF_DEB_MAX,
    parameter int LONG_W   = DEF_LONG_W,
    parameter int LONG_MAX = DEF_LONG_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_MAX - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_MAX);

    logic              s;
    btn_state_e        state_q, state_d;
    logic [DEB_W-1:0]  dcnt_q, dcnt_d;
    logic [LONG_W-1:0] lcnt_q, lcnt_d;
    logic              pressed_q, pressed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (s)
    );

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        lcnt_d    = lcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRS_CHK;
                    dcnt_d  = '0;
                end
            end
            ST_PRS_CHK: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    lcnt_d  = '0;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                // A release sample wins over a coincident long-press expiry.
                if (!s) begin
                    state_d = ST_REL_CHK;
                    dcnt_d  = '0;
                end else if (lcnt_q == LONG_LAST) begin
                    long_d = 1'b1;
                    lcnt_d = LONG_SAT;
                end else if (lcnt_q != LONG_SAT) begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            ST_REL_CHK: begin
                // Bouncing back to HELD keeps lcnt so long-press timing continues.
                if (s) begin
                    state_d = ST_HELD;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pressed_d = (state_d == ST_HELD) || (state_d == ST_REL_CHK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

`default_nettype wire
